alu_result_pipe: RTL and testbench

- Parametrised elastic pipeline register for ALU results and flags.
- Sits between the ALU and the writeback/forwarding logic, replacing the fixed single 32-bit result latch.
- Adds a configurable width and stage depth, a valid/ready handshake, a flush and occupancy reporting.
- All state updates on the falling edge of clk, so the ALU result is captured mid-cycle as the datapath expects.

---
 rtl/alu_pipe_pkg.sv | 18 +
 rtl/alu_pipe_stage.sv | 61 ++++++
 rtl/alu_result_pipe.sv | 101 ++++++++++
 tb/tb_alu_result_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared constants for the ALU result pipeline: default widths, flag bit
// positions and the occupancy counter width.
package alu_pipe_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int FLAGS_W_DEF = 4;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Bits needed to hold an occupancy value from 0 to depth inclusive.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One elastic pipeline stage, clocked on the falling edge: a valid bit that
// advances every edge and a payload that only loads when a valid entry arrives.
module alu_pipe_stage
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int FLAGS_W = FLAGS_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               ready_i,
   input  logic               vld_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic [FLAGS_W-1:0] flags_i,
   output logic               vld_d_o,
   output logic               vld_o,
   output logic [WIDTH-1:0]   data_o,
   output logic [FLAGS_W-1:0] flags_o
);

   logic               vld_q,   vld_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic               load;

   always_comb begin
      load    = ready_i & vld_i & ~flush_i;
      vld_d   = vld_q;
      data_d  = data_q;
      flags_d = flags_q;
      if (flush_i) begin
         vld_d = 1'b0;
      end else if (ready_i) begin
         vld_d = vld_i;
      end
      // Payload is left untouched by bubbles to avoid needless toggling.
      if (load) begin
         data_d  = data_i;
         flags_d = flags_i;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         vld_q   <= vld_d;
         data_q  <= data_d;
         flags_q <= flags_d;
      end
   end

   assign vld_d_o = vld_d;
   assign vld_o   = vld_q;
   assign data_o  = data_q;
   assign flags_o = flags_q;

endmodule

// File: rtl/alu_result_pipe.sv
// Elastic ALU result/flag pipeline of DEPTH negedge stages with valid/ready
// handshake, flush and registered occupancy count.
module alu_result_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int FLAGS_W = FLAGS_W_DEF,
   parameter int DEPTH   = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   input  logic [FLAGS_W-1:0]          in_flags,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [FLAGS_W-1:0]          out_flags,
   output logic [count_w(DEPTH)-1:0]   count
);

   localparam int CNT_W = count_w(DEPTH);

   if (DEPTH < 1) begin : g_depth_chk
      $error("alu_result_pipe: DEPTH must be at least 1");
   end

   logic [DEPTH-1:0]   vld, vld_nxt, rdy;
   logic [WIDTH-1:0]   data  [DEPTH];
   logic [FLAGS_W-1:0] flags [DEPTH];
   logic [CNT_W-1:0]   count_q, count_d;

   // A stage can advance unless it and every stage downstream are full
   // while the consumer stalls; this is the ready chain written flat.
   always_comb begin : ready_chain
      logic tail_full;
      tail_full = 1'b1;
      rdy       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         tail_full = tail_full & vld[i];
         rdy[i]    = out_ready | ~tail_full;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic               vld_src;
      logic [WIDTH-1:0]   data_src;
      logic [FLAGS_W-1:0] flags_src;

      if (i == 0) begin : g_head
         assign vld_src   = in_valid;
         assign data_src  = in_data;
         assign flags_src = in_flags;
      end else begin : g_body
         assign vld_src   = vld[i-1];
         assign data_src  = data[i-1];
         assign flags_src = flags[i-1];
      end

      alu_pipe_stage #(
         .WIDTH   (WIDTH),
         .FLAGS_W (FLAGS_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .flush_i (flush),
         .ready_i (rdy[i]),
         .vld_i   (vld_src),
         .data_i  (data_src),
         .flags_i (flags_src),
         .vld_d_o (vld_nxt[i]),
         .vld_o   (vld[i]),
         .data_o  (data[i]),
         .flags_o (flags[i])
      );
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + CNT_W'(vld_nxt[i]);
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign in_ready  = rst_n & rdy[0] & ~flush;
   assign out_valid = vld[DEPTH-1];
   assign out_data  = data[DEPTH-1];
   assign out_flags = flags[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_alu_result_pipe.sv
// Bench for alu_result_pipe: directed vector table, reset/flush corner cases,
// randomized traffic against a queue model, and a DEPTH=1 / WIDTH=8 build.
module tb_alu_result_pipe;
   import alu_pipe_pkg::*;

   localparam int DA = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        a_iv, a_ir, a_fl, a_ov, a_or;
   logic [31:0] a_d, a_od;
   logic [3:0]  a_f, a_of;
   logic [1:0]  a_cnt;

   logic        b_iv, b_ir, b_fl, b_ov, b_or;
   logic [7:0]  b_d, b_od;
   logic [3:0]  b_f, b_of;
   logic [0:0]  b_cnt;

   alu_result_pipe #(.WIDTH(32), .FLAGS_W(4), .DEPTH(DA)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_d), .in_flags(a_f), .flush(a_fl), .out_valid(a_ov),
      .out_ready(a_or), .out_data(a_od), .out_flags(a_of), .count(a_cnt)
   );

   alu_result_pipe #(.WIDTH(8), .FLAGS_W(4), .DEPTH(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
      .in_data(b_d), .in_flags(b_f), .flush(b_fl), .out_valid(b_ov),
      .out_ready(b_or), .out_data(b_od), .out_flags(b_of), .count(b_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic edge_wait();
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic [3:0]  f;
      logic        orr;
      logic        fl;
      logic        ir;
      logic        ov;
      logic [31:0] od;
      logic [3:0]  of;
      logic [1:0]  cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic iv, input logic [31:0] d, input logic [3:0] f,
                      input logic orr, input logic fl, input logic ir, input logic ov,
                      input logic [31:0] od, input logic [3:0] of, input logic [1:0] cnt);
      vec_t v;
      v.iv = iv; v.d = d; v.f = f; v.orr = orr; v.fl = fl;
      v.ir = ir; v.ov = ov; v.od = od; v.of = of; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   // Reference model: ordered list of held entries, each tagged with the
   // stage it currently occupies (oldest first).
   typedef struct {
      logic [31:0] d;
      logic [3:0]  f;
      int          pos;
   } ent_t;

   ent_t q[$];

   task automatic model_step(input bit acc, input bit fl, input bit orr,
                             input logic [31:0] d, input logic [3:0] f);
      int   lim;
      ent_t e;
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() > 0 && q[0].pos == DA - 1 && orr) void'(q.pop_front());
         lim = DA - 1;
         foreach (q[k]) begin
            q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
            lim      = q[k].pos - 1;
         end
         if (acc) begin
            e.d = d; e.f = f; e.pos = 0;
            q.push_back(e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          exp_ir, exp_ov;
      logic [7:0]  val;

      rst_n = 1'b0;
      a_iv = 0; a_d = '0; a_f = '0; a_fl = 0; a_or = 0;
      b_iv = 0; b_d = '0; b_f = '0; b_fl = 0; b_or = 0;

      #12;
      chk("rst a out_valid", 32'(a_ov), 32'(0));
      chk("rst a out_data",  a_od, 32'(0));
      chk("rst a out_flags", 32'(a_of), 32'(0));
      chk("rst a count",     32'(a_cnt), 32'(0));
      chk("rst a in_ready",  32'(a_ir), 32'(0));
      chk("rst b out_valid", 32'(b_ov), 32'(0));
      chk("rst b count",     32'(b_cnt), 32'(0));
      chk("rst b in_ready",  32'(b_ir), 32'(0));
      #1 rst_n = 1'b1;
      edge_wait();

      // single value, stream 1..5, backpressure 7/8/9, flush with DEAD
      add(1, 'hA5,   'h0, 1, 0, 1, 0, 0,     'h0, 1);
      add(0, 0,      'h0, 1, 0, 1, 1, 'hA5,  'h0, 1);
      add(0, 0,      'h0, 1, 0, 1, 0, 0,     'h0, 0);
      add(1, 1,      'h2, 1, 0, 1, 0, 0,     'h0, 1);
      add(1, 2,      'h4, 1, 0, 1, 1, 1,     'h2, 2);
      add(1, 3,      'h8, 1, 0, 1, 1, 2,     'h4, 2);
      add(1, 4,      'h1, 1, 0, 1, 1, 3,     'h8, 2);
      add(1, 5,      'h3, 1, 0, 1, 1, 4,     'h1, 2);
      add(0, 0,      'h0, 1, 0, 1, 1, 5,     'h3, 1);
      add(0, 0,      'h0, 1, 0, 1, 0, 0,     'h0, 0);
      add(1, 7,      'h7, 0, 0, 1, 0, 0,     'h0, 1);
      add(1, 8,      'h8, 0, 0, 1, 1, 7,     'h7, 2);
      add(1, 9,      'h9, 0, 0, 0, 1, 7,     'h7, 2);
      add(1, 9,      'h9, 1, 0, 1, 1, 8,     'h8, 2);
      add(0, 0,      'h0, 1, 0, 1, 1, 9,     'h9, 1);
      add(0, 0,      'h0, 1, 0, 1, 0, 0,     'h0, 0);
      add(1, 'h11,   'hC, 0, 0, 1, 0, 0,     'h0, 1);
      add(1, 'h22,   'hD, 0, 0, 1, 1, 'h11,  'hC, 2);
      add(1, 'hDEAD, 'hE, 1, 1, 0, 0, 0,     'h0, 0);
      add(0, 0,      'h0, 1, 0, 1, 0, 0,     'h0, 0);

      foreach (tbl[k]) begin
         a_iv = tbl[k].iv; a_d = tbl[k].d; a_f = tbl[k].f;
         a_or = tbl[k].orr; a_fl = tbl[k].fl;
         #2;
         chk($sformatf("vec%0d in_ready", k), 32'(a_ir), 32'(tbl[k].ir));
         edge_wait();
         chk($sformatf("vec%0d out_valid", k), 32'(a_ov), 32'(tbl[k].ov));
         chk($sformatf("vec%0d count", k), 32'(a_cnt), 32'(tbl[k].cnt));
         if (tbl[k].ov) begin
            chk($sformatf("vec%0d out_data", k), a_od, tbl[k].od);
            chk($sformatf("vec%0d out_flags", k), 32'(a_of), 32'(tbl[k].of));
         end
      end
      a_fl = 0;

      // asynchronous reset while full, then 2-edge latency after release
      a_or = 0; a_iv = 1; a_d = 'h55; a_f = 'h1;
      edge_wait();
      a_d = 'h66; a_f = 'h2;
      edge_wait();
      a_iv = 0;
      chk("areset pre count", 32'(a_cnt), 32'(2));
      #2 rst_n = 1'b0;
      #1;
      chk("areset out_valid", 32'(a_ov), 32'(0));
      chk("areset out_data",  a_od, 32'(0));
      chk("areset out_flags", 32'(a_of), 32'(0));
      chk("areset count",     32'(a_cnt), 32'(0));
      chk("areset in_ready",  32'(a_ir), 32'(0));
      #1 rst_n = 1'b1;
      a_iv = 1; a_d = 'h1234; a_f = 'h5; a_or = 1;
      #1;
      chk("post-rst in_ready", 32'(a_ir), 32'(1));
      edge_wait();
      a_iv = 0;
      chk("post-rst edge1 out_valid", 32'(a_ov), 32'(0));
      chk("post-rst edge1 count", 32'(a_cnt), 32'(1));
      edge_wait();
      chk("post-rst edge2 out_valid", 32'(a_ov), 32'(1));
      chk("post-rst edge2 out_data", a_od, 32'h1234);
      chk("post-rst edge2 out_flags", 32'(a_of), 32'(5));
      edge_wait();
      chk("post-rst drain count", 32'(a_cnt), 32'(0));

      // randomized traffic against the queue model
      q.delete();
      for (int n = 0; n < 400; n++) begin
         a_iv = 1'($urandom_range(0, 1));
         a_d  = $urandom;
         a_f  = 4'($urandom);
         a_or = ($urandom_range(0, 9) < 7);
         a_fl = ($urandom_range(0, 19) == 0);
         exp_ir = !a_fl && (q.size() < DA || a_or);
         #2;
         chk($sformatf("rnd%0d in_ready", n), 32'(a_ir), 32'(exp_ir));
         model_step(exp_ir && a_iv, a_fl, a_or, a_d, a_f);
         edge_wait();
         exp_ov = (q.size() > 0) && (q[0].pos == DA - 1);
         chk($sformatf("rnd%0d out_valid", n), 32'(a_ov), 32'(exp_ov));
         chk($sformatf("rnd%0d count", n), 32'(a_cnt), 32'(q.size()));
         if (exp_ov) begin
            chk($sformatf("rnd%0d out_data", n), a_od, q[0].d);
            chk($sformatf("rnd%0d out_flags", n), 32'(a_of), 32'(q[0].f));
         end
      end
      a_iv = 0; a_fl = 0; a_or = 1;

      // DEPTH=1, WIDTH=8: full pass-through every edge
      b_or = 1;
      val = '0;
      for (int k = 0; k < 8; k++) begin
         val  = 8'(8'h10 + k * 7);
         b_iv = 1; b_d = val; b_f = val[3:0];
         #2;
         chk($sformatf("b%0d in_ready", k), 32'(b_ir), 32'(1));
         edge_wait();
         chk($sformatf("b%0d out_valid", k), 32'(b_ov), 32'(1));
         chk($sformatf("b%0d out_data", k), 32'(b_od), 32'(val));
         chk($sformatf("b%0d out_flags", k), 32'(b_of), 32'(val[3:0]));
         chk($sformatf("b%0d count", k), 32'(b_cnt), 32'(1));
      end
      b_or = 0; b_iv = 1; b_d = 'hEE; b_f = 'hE;
      #2;
      chk("b full in_ready", 32'(b_ir), 32'(0));
      edge_wait();
      chk("b full out_data", 32'(b_od), 32'(val));
      chk("b full count", 32'(b_cnt), 32'(1));
      b_or = 1; b_iv = 0;
      edge_wait();
      chk("b drain out_valid", 32'(b_ov), 32'(0));
      chk("b drain count", 32'(b_cnt), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
